// File: rtl/pwm_dac_multi_if.sv
// ----------------------------------------------------------------------------
// pwm_dac_multi_if
// System-bus bundle for the pwm_dac_multi register block.
//   sys_addr   : byte address (the slave decodes [19:0])
//   sys_wdata  : write data
//   sys_wen    : write strobe
//   sys_ren    : read strobe
//   sys_rdata  : read data, valid together with sys_ack
//   sys_err    : error flag (never raised by pwm_dac_multi)
//   sys_ack    : registered acknowledge, one cycle after a strobe
// ----------------------------------------------------------------------------
interface pwm_dac_multi_if;
    logic [31:0] sys_addr;
    logic [31:0] sys_wdata;
    logic        sys_wen;
    logic        sys_ren;
    logic [31:0] sys_rdata;
    logic        sys_err;
    logic        sys_ack;

    modport master (
        output sys_addr, sys_wdata, sys_wen, sys_ren,
        input  sys_rdata, sys_err, sys_ack
    );

    modport slave (
        input  sys_addr, sys_wdata, sys_wen, sys_ren,
        output sys_rdata, sys_err, sys_ack
    );
endinterface

// File: rtl/pwm_dac_multi.sv
// ----------------------------------------------------------------------------
// pwm_dac_multi
// Multi-channel PWM DAC with fractional dither. Each channel turns a signed
// DW-bit sample into a PWM stream with a 2^PW-clock base period; the next MW
// bits below the duty field are spread as +1 clock over 2^MW periods.
// Samples are latched into a per-channel shadow at the last clock of every
// period, so updates are always period-aligned and glitch-free.
//
// Build option: define PWM_DITHER_EN to enable the fractional dither and the
// period counter (pcnt). Without it, hi = duty and pcnt reads as 0.
//
// Ports:
//   clk_i   : clock
//   rstn_i  : asynchronous active-low reset
//   dat_i   : NCH signed samples, channel k at [k*DW +: DW]
//   pwm_o   : registered PWM outputs
//   sync_o  : one-cycle pulse on the first output clock of each period
//   sys     : register bus (slave modport of pwm_dac_multi_if)
//
// Registers: 0x00+4k manual value ch k, 0x40 source select (1 = manual),
//            0x44 enable mask (reset all ones), 0x48 RO {pcnt, cnt}.
// ----------------------------------------------------------------------------
module pwm_dac_multi #(
    parameter int unsigned NCH = 4,
    parameter int unsigned DW  = 14,
    parameter int unsigned PW  = 8,
    parameter int unsigned MW  = 4
) (
    input  logic                clk_i,
    input  logic                rstn_i,
    input  logic [NCH*DW-1:0]   dat_i,
    output logic [NCH-1:0]      pwm_o,
    output logic                sync_o,
    pwm_dac_multi_if.slave      sys
);

    localparam logic [PW-1:0] CNT_MAX   = '1;
    localparam logic [19:0]   ADDR_SEL  = 20'h00040;
    localparam logic [19:0]   ADDR_EN   = 20'h00044;
    localparam logic [19:0]   ADDR_STAT = 20'h00048;

    logic [PW-1:0]               r_cnt;
    logic [NCH-1:0][DW-1:0]      r_manual;
    logic [NCH-1:0][DW-1:0]      r_shadow;
    logic [NCH-1:0]              r_sel;
    logic [NCH-1:0]              r_mask;
    logic                        r_ack;
    logic [31:0]                 r_rdata;

    logic                        w_wrap;
    logic [PW-1:0]               w_cnt_nxt;
    logic [MW-1:0]               w_pcnt;
    logic [NCH-1:0][DW-1:0]      w_src;
    logic [NCH-1:0][DW-1:0]      w_shadow_nxt;
    logic [NCH-1:0]              w_pwm_nxt;
    logic [19:0]                 w_addr;
    logic [31:0]                 w_rd_data;
    logic                        w_unused;

    assign w_wrap    = (r_cnt == CNT_MAX);
    assign w_cnt_nxt = r_cnt + PW'(1);
    assign w_addr    = sys.sys_addr[19:0];
    assign w_unused  = ^{sys.sys_addr[31:20], sys.sys_wdata};

`ifdef PWM_DITHER_EN
    logic [MW-1:0] r_pcnt;
    logic [MW-1:0] w_pcnt_nxt;

    assign w_pcnt_nxt = w_wrap ? r_pcnt + MW'(1) : r_pcnt;
    assign w_pcnt     = r_pcnt;

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_pcnt <= '0;
        end else begin
            r_pcnt <= w_pcnt_nxt;
        end
    end

    // Bit-reversed period index gives an evenly interleaved dither pattern.
    function automatic logic [MW-1:0] bitrev(input logic [MW-1:0] v);
        logic [MW-1:0] r;
        r = '0;
        for (int unsigned i = 0; i < MW; i++) begin
            r[i] = v[MW-1-i];
        end
        return r;
    endfunction
`else
    assign w_pcnt = '0;
`endif

    // pwm_o is registered, so the next-cycle value is built from the next
    // counter value and the shadow content that will hold after this edge
    // (the live source on the wrap edge). This puts the first high clock of
    // a new sample right on the first clock of its period.
    always_comb begin
        logic [PW-1:0] w_duty;
        logic [PW:0]   w_hi;
        logic          w_extra;
        w_src        = '0;
        w_shadow_nxt = '0;
        w_pwm_nxt    = '0;
        w_duty       = '0;
        w_hi         = '0;
        w_extra      = 1'b0;
        for (int unsigned k = 0; k < NCH; k++) begin
            w_src[k]        = r_sel[k] ? r_manual[k] : dat_i[k*DW +: DW];
            w_shadow_nxt[k] = w_wrap ? w_src[k] : r_shadow[k];
            // Offset binary: invert the sign bit, keep the top PW bits.
            w_duty = {~w_shadow_nxt[k][DW-1], w_shadow_nxt[k][DW-2 -: PW-1]};
`ifdef PWM_DITHER_EN
            w_extra = (w_shadow_nxt[k][DW-PW-1 -: MW] > bitrev(w_pcnt_nxt));
`else
            w_extra = 1'b0;
`endif
            w_hi         = {1'b0, w_duty} + {{PW{1'b0}}, w_extra};
            w_pwm_nxt[k] = r_mask[k] & ({1'b0, w_cnt_nxt} < w_hi);
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_cnt    <= '0;
            r_shadow <= '0;
            pwm_o    <= '0;
            sync_o   <= 1'b0;
        end else begin
            r_cnt    <= w_cnt_nxt;
            r_shadow <= w_shadow_nxt;
            pwm_o    <= w_pwm_nxt;
            sync_o   <= (w_cnt_nxt == '0);
        end
    end

    always_comb begin
        w_rd_data = '0;
        for (int unsigned k = 0; k < NCH; k++) begin
            if (w_addr == 20'(4*k)) begin
                w_rd_data = 32'(r_manual[k]);
            end
        end
        case (w_addr)
            ADDR_SEL:  w_rd_data = 32'(r_sel);
            ADDR_EN:   w_rd_data = 32'(r_mask);
            ADDR_STAT: w_rd_data = 32'({w_pcnt, r_cnt});
            default:   ;
        endcase
    end

    // Register writes land on the acking edge; the shadow load on that same
    // edge still sees the previous register value.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_manual <= '0;
            r_sel    <= '0;
            r_mask   <= '1;
            r_ack    <= 1'b0;
            r_rdata  <= '0;
        end else begin
            r_ack   <= sys.sys_wen | sys.sys_ren;
            r_rdata <= sys.sys_ren ? w_rd_data : '0;
            if (sys.sys_wen) begin
                for (int unsigned k = 0; k < NCH; k++) begin
                    if (w_addr == 20'(4*k)) begin
                        r_manual[k] <= sys.sys_wdata[DW-1:0];
                    end
                end
                if (w_addr == ADDR_SEL) begin
                    r_sel <= sys.sys_wdata[NCH-1:0];
                end
                if (w_addr == ADDR_EN) begin
                    r_mask <= sys.sys_wdata[NCH-1:0];
                end
            end
        end
    end

    assign sys.sys_ack   = r_ack;
    assign sys.sys_rdata = r_rdata;
    assign sys.sys_err   = 1'b0;

endmodule

// File: tb/tb_pwm_dac_multi.sv
// ----------------------------------------------------------------------------
// tb_pwm_dac_multi
// Scoreboard bench for pwm_dac_multi (NCH=4, DW=14, PW=8, MW=4).
// Stimulus pushes expected per-period high counts and expected bus responses;
// the monitor pops and compares on each sync_o boundary and each sys_ack.
// Honours PWM_DITHER_EN for the expected dither counts.
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_pwm_dac_multi;
    localparam int NCH = 4;
    localparam int DW  = 14;
    localparam int PW  = 8;
    localparam int MW  = 4;
`ifdef PWM_DITHER_EN
    localparam bit DITH = 1'b1;
`else
    localparam bit DITH = 1'b0;
`endif

    // ch3..ch0
    localparam logic [NCH*DW-1:0] DAT_A = {14'h0004, 14'h2000, 14'h1FFF, 14'h0000};
    localparam logic [NCH*DW-1:0] DAT_B = {14'h0004, 14'h3FFF, 14'h1FFF, 14'h0000};

    logic               clk_i = 1'b0;
    logic               rstn_i;
    logic [NCH*DW-1:0]  dat_i;
    logic [NCH-1:0]     pwm_o;
    logic               sync_o;

    pwm_dac_multi_if sys_if();

    pwm_dac_multi #(.NCH(NCH), .DW(DW), .PW(PW), .MW(MW)) dut (
        .clk_i  (clk_i),
        .rstn_i (rstn_i),
        .dat_i  (dat_i),
        .pwm_o  (pwm_o),
        .sync_o (sync_o),
        .sys    (sys_if)
    );

    always #5 clk_i = ~clk_i;

    int errors = 0;
    int checks = 0;
    int cyc;

    always @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) cyc <= 0;
        else         cyc <= cyc + 1;
    end

    typedef struct {
        int          cyc;
        bit          rd;
        logic [31:0] addr;
        logic [31:0] data;
    } bus_exp_t;

    bus_exp_t        bus_q[$];
    logic [35:0]     per_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    // Hand-derived high counts per period index pc.
    function automatic int hmax(int pc);  // 0x1FFF
        return DITH ? ((pc % 16 == 15) ? 255 : 256) : 255;
    endfunction
    function automatic int hneg(int pc);  // 0x3FFF (-1)
        return DITH ? ((pc % 16 == 15) ? 127 : 128) : 127;
    endfunction
    function automatic int hlow(int pc);  // 0x0004
        return DITH ? ((pc % 16 == 0) ? 129 : 128) : 128;
    endfunction

    function automatic logic [35:0] pk(int h0, int h1, int h2, int h3);
        return {9'(h3), 9'(h2), 9'(h1), 9'(h0)};
    endfunction

    // {pcnt, cnt} as sampled on the edge that ends cycle k-1 after release.
    function automatic logic [31:0] exp_stat(int k);
        int c;
        int p;
        c = (k - 1) % 256;
        p = DITH ? ((k - 1) / 256) % 16 : 0;
        return 32'(p * 256 + c);
    endfunction

    task automatic summary_and_finish();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    endtask

    // Called on a negedge; leaves the bus idle on the following negedge.
    task automatic bus(input bit wr, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [31:0] exp_rd);
        bus_exp_t e;
        sys_if.sys_addr  = addr;
        sys_if.sys_wdata = wdata;
        sys_if.sys_wen   = wr;
        sys_if.sys_ren   = !wr;
        e.cyc  = cyc + 1;
        e.rd   = !wr;
        e.addr = addr;
        e.data = exp_rd;
        bus_q.push_back(e);
        @(negedge clk_i);
        sys_if.sys_wen = 1'b0;
        sys_if.sys_ren = 1'b0;
    endtask

    task automatic read_regs();
        bus(1'b0, 32'h0000_0004, 32'h0, 32'h0);
        bus(1'b0, 32'h0000_0040, 32'h0, 32'h0);
        bus(1'b0, 32'h0000_0044, 32'h0, 32'h0000_000F);
        bus(1'b0, 32'h0000_0048, 32'h0, exp_stat(cyc + 1));
        bus(1'b0, 32'h0000_0050, 32'h0, 32'h0);
    endtask

    task automatic wait_sync(inout int n);
        bit found;
        found = 1'b0;
        for (int t = 0; t < 600 && !found; t++) begin
            @(negedge clk_i);
            if (sync_o) found = 1'b1;
        end
        if (!found) begin
            errors++;
            checks++;
            $display("FAIL sync_timeout: actual=no sync_o within 600 clocks required=sync_o every 256");
            summary_and_finish();
        end
        n++;
    endtask

    // Monitor: measures each period between sync_o pulses and every bus ack.
    initial begin : monitor
        bit          started;
        int          len;
        int          hc [NCH];
        logic [35:0] ex;
        bus_exp_t    be;
        started = 1'b0;
        len     = 0;
        foreach (hc[k]) hc[k] = 0;
        forever begin
            @(negedge clk_i);
            if (!rstn_i) begin
                started = 1'b0;
                len     = 0;
            end else begin
                if (sync_o) begin
                    if (started) begin
                        chk("period_len", 32'(len), 32'd256);
                        if (per_q.size() == 0) begin
                            errors++;
                            checks++;
                            $display("FAIL period_exp: actual=period completed required=expectation queued");
                        end else begin
                            ex = per_q.pop_front();
                            for (int k = 0; k < NCH; k++) begin
                                chk($sformatf("ch%0d_high", k), 32'(hc[k]), 32'(ex[k*9 +: 9]));
                            end
                        end
                    end
                    started = 1'b1;
                    len     = 0;
                    foreach (hc[k]) hc[k] = 0;
                end
                if (started) begin
                    len++;
                    for (int k = 0; k < NCH; k++) begin
                        if (pwm_o[k]) hc[k]++;
                    end
                end
                if (sys_if.sys_ack) begin
                    if (bus_q.size() == 0) begin
                        errors++;
                        checks++;
                        $display("FAIL ack_unexpected: actual=ack at cycle %0d required=no ack", cyc);
                    end else begin
                        be = bus_q.pop_front();
                        chk("ack_cycle", 32'(cyc), 32'(be.cyc));
                        chk("sys_err", {31'b0, sys_if.sys_err}, 32'h0);
                        if (be.rd) chk($sformatf("rdata_%0h", be.addr), sys_if.sys_rdata, be.data);
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #1_000_000;
        errors++;
        checks++;
        $display("FAIL watchdog: actual=simulation still running required=finished");
        summary_and_finish();
    end

    initial begin : stimulus
        int n;
        rstn_i           = 1'b0;
        dat_i            = DAT_A;
        sys_if.sys_addr  = '0;
        sys_if.sys_wdata = '0;
        sys_if.sys_wen   = 1'b0;
        sys_if.sys_ren   = 1'b0;
        repeat (3) @(negedge clk_i);
        chk("rst_pwm",   32'(pwm_o), 32'h0);
        chk("rst_sync",  32'(sync_o), 32'h0);
        chk("rst_ack",   32'(sys_if.sys_ack), 32'h0);
        chk("rst_err",   32'(sys_if.sys_err), 32'h0);
        chk("rst_rdata", sys_if.sys_rdata, 32'h0);

        rstn_i = 1'b1;
        n = 0;
        per_q.push_back(pk(128, hmax(1), 0, hlow(1)));
        read_regs();
        wait_sync(n);
        chk("first_sync_cycle", 32'(cyc), 32'd256);

        // Periods 1..16: fixed samples, dither sequence through pcnt 15 and 0.
        while (n < 16) begin
            repeat (100) @(negedge clk_i);
            per_q.push_back(pk(128, hmax(n + 1), 0, hlow(n + 1)));
            wait_sync(n);
        end

        // Period 16: mid-period register writes and source change.
        repeat (50) @(negedge clk_i);
        dat_i = DAT_B;
        bus(1'b1, 32'h0000_0004, 32'h0000_1000, 32'h0);
        bus(1'b1, 32'h0000_0040, 32'h0000_0002, 32'h0);
        bus(1'b0, 32'h0000_0004, 32'h0, 32'h0000_1000);
        bus(1'b0, 32'h0000_0040, 32'h0, 32'h0000_0002);
        bus(1'b0, 32'h0000_0048, 32'h0, exp_stat(cyc + 1));
        bus(1'b1, 32'h0000_0100, 32'h0000_FFFF, 32'h0);
        bus(1'b0, 32'h0000_0100, 32'h0, 32'h0);
        bus(1'b0, 32'h0000_0008, 32'h0, 32'h0);
        per_q.push_back(pk(128, 192, hneg(n + 1), hlow(n + 1)));
        wait_sync(n);

        // Period 17: disable ch3 late in the period.
        repeat (210) @(negedge clk_i);
        bus(1'b1, 32'h0000_0044, 32'h0000_0007, 32'h0);
        per_q.push_back(pk(128, 192, hneg(n + 1), 0));
        wait_sync(n);

        // Period 18: re-enable ch3, ch1 back to dat_i; upper address bits ignored.
        repeat (210) @(negedge clk_i);
        bus(1'b1, 32'h0000_0044, 32'h0000_000F, 32'h0);
        bus(1'b1, 32'h0000_0040, 32'h0000_0000, 32'h0);
        bus(1'b0, 32'hABC0_0044, 32'h0, 32'h0000_000F);
        per_q.push_back(pk(128, hmax(n + 1), hneg(n + 1), hlow(n + 1)));
        wait_sync(n);

        repeat (100) @(negedge clk_i);
        per_q.push_back(pk(128, hmax(n + 1), hneg(n + 1), hlow(n + 1)));
        wait_sync(n);

        // Period 20: asynchronous reset while ch0 is high.
        repeat (10) @(negedge clk_i);
        chk("pre_reset_ch0", 32'(pwm_o[0]), 32'h1);
        #2;
        rstn_i = 1'b0;
        #1;
        chk("async_rst_pwm",   32'(pwm_o), 32'h0);
        chk("async_rst_sync",  32'(sync_o), 32'h0);
        chk("async_rst_ack",   32'(sys_if.sys_ack), 32'h0);
        chk("async_rst_rdata", sys_if.sys_rdata, 32'h0);
        per_q.delete();
        bus_q.delete();
        dat_i = DAT_A;
        repeat (3) @(negedge clk_i);
        rstn_i = 1'b1;
        n = 0;
        per_q.push_back(pk(128, hmax(1), 0, hlow(1)));
        read_regs();
        wait_sync(n);
        chk("restart_sync_cycle", 32'(cyc), 32'd256);
        wait_sync(n);

        repeat (3) @(negedge clk_i);
        chk("bus_pending", 32'(bus_q.size()), 32'h0);
        chk("period_pending", 32'(per_q.size()), 32'h0);
        summary_and_finish();
    end

endmodule
